fifo_rd_packer: RTL and testbench

//  Read-side consumer of the async FIFO. Runs entirely in the read-clock domain.

---
 rtl/fifo_rd_packer_if.sv | 14 +
 rtl/fifo_rd_packer.sv | 55 +++++
 tb/tb_fifo_rd_packer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_packer_if.sv
// fifo_rd_packer_if: FIFO read port and packed output stream of the read-side packer
interface fifo_rd_packer_if #(
  parameter int DATASIZE = 8,
  parameter int PACK     = 4
);
  logic                     rempty;
  logic [DATASIZE-1:0]      rdata;
  logic                     r_req_val;
  logic [DATASIZE*PACK-1:0] m_data;
  logic                     m_valid;
  logic                     m_ready;
  modport master (input rempty, rdata, m_ready, output r_req_val, m_data, m_valid);
  modport slave  (output rempty, rdata, m_ready, input r_req_val, m_data, m_valid);
endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops FIFO entries and packs PACK of them, first entry in the LSBs, into one stream word
module fifo_rd_packer #(
  parameter int DATASIZE = 8,
  parameter int PACK     = 4
) (
  input  logic rclk,
  input  logic rrst_n,
  input  logic flush,
  output logic busy,
  fifo_rd_packer_if.master bus
);
  localparam int CW = $clog2(PACK + 1);
  localparam logic [CW-1:0] LAST = CW'(PACK - 1);
  logic [CW-1:0]                cnt;
  logic [CW-1:0]                slots;
  logic                         inflight;
  logic                         pop;
  logic [DATASIZE*(PACK-1)-1:0] asm_q;
  logic [DATASIZE*PACK-1:0]     m_data_q;
  logic                         m_valid_q;
  // Pop throttle: the completing pop is only issued when the output register will be free to take the word
  always_comb begin
    slots = cnt + CW'(inflight);
    pop   = rrst_n && !bus.rempty && !flush &&
            (slots < LAST || (slots == LAST && (!m_valid_q || bus.m_ready)));
  end
  assign bus.r_req_val = pop;
  assign bus.m_data    = m_data_q;
  assign bus.m_valid   = m_valid_q;
  assign busy          = (cnt != '0) || inflight;
  // Capture returning entries into lanes, emit the word on the last lane, and run the output handshake
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt       <= '0;
      inflight  <= 1'b0;
      asm_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      inflight  <= pop;
      m_valid_q <= (inflight && !flush && cnt == LAST) || (m_valid_q && !bus.m_ready);
      if (flush) begin
        cnt <= '0;
      end else if (inflight) begin
        if (cnt == LAST) begin
          cnt      <= '0;
          m_data_q <= {bus.rdata, asm_q};
        end else begin
          asm_q[cnt*DATASIZE +: DATASIZE] <= bus.rdata;
          cnt                             <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed and random checks of fifo_rd_packer against a queue-based packing model
module tb_fifo_rd_packer;
  localparam int D = 8;
  localparam int P = 4;
  logic rclk = 1'b0;
  logic rrst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;
  fifo_rd_packer_if #(.DATASIZE(D), .PACK(P)) bus ();
  fifo_rd_packer #(.DATASIZE(D), .PACK(P)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .flush(flush), .busy(busy), .bus(bus)
  );
  always #5 rclk = ~rclk;
  int checks = 0;
  int failures = 0;
  int vcycles = 0;
  bit infl = 1'b0;
  bit hold_empty = 1'b0;
  logic [D-1:0]   src[$];
  logic [D-1:0]   pend[$];
  logic [D*P-1:0] ew[$];
  logic [D*P-1:0] got[$];
  logic [D*P-1:0] exp6[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One read-clock cycle: check outputs against the model, then advance FIFO and model past the edge
  task automatic cycle();
    bit pop, acc, rule;
    int slots;
    logic [D*P-1:0] w;
    bus.rempty = hold_empty || src.size() == 0;
    #2;
    slots = pend.size() + int'(infl);
    rule = !bus.rempty && !flush &&
           (slots < P - 1 || (slots == P - 1 && (ew.size() == 0 || bus.m_ready)));
    chk("m_valid", bus.m_valid, ew.size() != 0);
    if (ew.size() != 0) chk("m_data", bus.m_data, ew[0]);
    chk("busy", busy, pend.size() != 0 || infl);
    chk("r_req_val", bus.r_req_val, rule);
    if (bus.r_req_val) chk("pop_while_empty", bus.rempty, 0);
    pop = bus.r_req_val;
    acc = bus.m_valid && bus.m_ready;
    if (bus.m_valid) vcycles++;
    if (acc) got.push_back(bus.m_data);
    @(posedge rclk);
    if (ew.size() != 0 && bus.m_ready) void'(ew.pop_front());
    if (flush) pend.delete();
    else if (infl) begin
      pend.push_back(bus.rdata);
      if (pend.size() == P) begin
        w = '0;
        for (int i = 0; i < P; i++) w[i*D +: D] = pend[i];
        ew.push_back(w);
        pend.delete();
      end
    end
    infl = pop;
    #1;
    if (pop && src.size() != 0) bus.rdata = src.pop_front();
    else bus.rdata = D'($urandom);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((src.size() != 0 || pend.size() != 0 || infl || ew.size() != 0) && n < max) begin
      cycle();
      n++;
    end
    chk("drain_timeout", n < max, 1);
  endtask

  task automatic reset_async();
    #2 rrst_n = 1'b0;
    #1;
    chk("rst_r_req_val", bus.r_req_val, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_busy", busy, 0);
    pend.delete();
    ew.delete();
    infl = 1'b0;
    @(posedge rclk);
    #1 rrst_n = 1'b1;
  endtask

  initial begin
    bus.rempty = 1'b1;
    bus.rdata = '0;
    bus.m_ready = 1'b1;
    #1;
    chk("init_m_valid", bus.m_valid, 0);
    chk("init_m_data", bus.m_data, 0);
    chk("init_busy", busy, 0);
    chk("init_r_req_val", bus.r_req_val, 0);
    repeat (2) @(posedge rclk);
    #1 rrst_n = 1'b1;
    // basic packing with continuous ready
    for (int i = 1; i <= 8; i++) src.push_back(D'(i));
    vcycles = 0;
    got.delete();
    drain(60);
    chk("t1_words", got.size(), 2);
    chk("t1_word0", got.size() > 0 ? got[0] : 'x, 32'h04030201);
    chk("t1_word1", got.size() > 1 ? got[1] : 'x, 32'h08070605);
    chk("t1_valid_cycles", vcycles, 2);
    // backpressure
    bus.m_ready = 1'b0;
    for (int i = 'h11; i <= 'h18; i++) src.push_back(D'(i));
    got.delete();
    repeat (12) cycle();
    #1;
    chk("t2_held_valid", bus.m_valid, 1);
    chk("t2_held_data", bus.m_data, 32'h14131211);
    chk("t2_throttle", bus.r_req_val, 0);
    chk("t2_busy", busy, 1);
    bus.m_ready = 1'b1;
    drain(60);
    chk("t2_words", got.size(), 2);
    chk("t2_word0", got.size() > 0 ? got[0] : 'x, 32'h14131211);
    chk("t2_word1", got.size() > 1 ? got[1] : 'x, 32'h18171615);
    // FIFO runs empty mid-word
    got.delete();
    src.push_back(8'h21);
    src.push_back(8'h22);
    repeat (6) cycle();
    #1;
    chk("t3_busy", busy, 1);
    chk("t3_no_valid", bus.m_valid, 0);
    src.push_back(8'h23);
    src.push_back(8'h24);
    drain(40);
    chk("t3_words", got.size(), 1);
    chk("t3_word0", got.size() > 0 ? got[0] : 'x, 32'h24232221);
    // flush with two lanes assembled and one entry in flight
    src.push_back(8'h31);
    src.push_back(8'h32);
    src.push_back(8'h33);
    repeat (3) cycle();
    #1 chk("t4_busy_pre", busy, 1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("t4_busy_post", busy, 0);
    got.delete();
    for (int i = 'h41; i <= 'h44; i++) src.push_back(D'(i));
    drain(40);
    chk("t4_words", got.size(), 1);
    chk("t4_word0", got.size() > 0 ? got[0] : 'x, 32'h44434241);
    // asynchronous reset mid-word, then while a word is held
    for (int i = 'h51; i <= 'h56; i++) src.push_back(D'(i));
    repeat (2) cycle();
    reset_async();
    src.delete();
    got.delete();
    for (int i = 'h61; i <= 'h64; i++) src.push_back(D'(i));
    drain(40);
    chk("t5a_word0", got.size() > 0 ? got[0] : 'x, 32'h64636261);
    bus.m_ready = 1'b0;
    for (int i = 'h71; i <= 'h78; i++) src.push_back(D'(i));
    repeat (10) cycle();
    #1 chk("t5_held_valid", bus.m_valid, 1);
    reset_async();
    src.delete();
    bus.m_ready = 1'b1;
    got.delete();
    for (int i = 'h81; i <= 'h84; i++) src.push_back(D'(i));
    drain(40);
    chk("t5b_word0", got.size() > 0 ? got[0] : 'x, 32'h84838281);
    // random availability and backpressure over 1000 entries
    got.delete();
    exp6.delete();
    begin
      logic [D*P-1:0] w;
      int n;
      for (int i = 0; i < 1000; i++) begin
        src.push_back(D'($urandom));
        w[(i % P)*D +: D] = src[i];
        if (i % P == P - 1) exp6.push_back(w);
      end
      n = 0;
      while ((src.size() != 0 || pend.size() != 0 || infl || ew.size() != 0) && n < 20000) begin
        hold_empty = $urandom_range(0, 3) == 0;
        bus.m_ready = $urandom_range(0, 2) != 0;
        cycle();
        n++;
      end
      chk("t6_timeout", n < 20000, 1);
    end
    hold_empty = 1'b0;
    bus.m_ready = 1'b1;
    drain(100);
    chk("t6_words", got.size(), 250);
    for (int i = 0; i < 250; i++)
      chk($sformatf("t6_word%0d", i), i < got.size() ? got[i] : 'x, exp6[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
